// File: rtl/rf_wb_scoreboard.sv
// Write-back controller for the RV32E register file: round-robin ALU/LSU arbitration onto the
// single write port, plus a pending-register scoreboard that holds issue on RAW/WAW hazards.
module rf_wb_scoreboard #(
  parameter int NREGS  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_rd_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_rd_i,
  input  logic [ADDR_W-1:0] iss_rs1_i,
  input  logic [ADDR_W-1:0] iss_rs2_i,
  output logic              iss_stall_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [NREGS-1:0]  pending_o,
  output logic              err_o
);

  localparam logic LG_ALU = 1'b0;
  localparam logic LG_LSU = 1'b1;

  // One-hot decode of a register address; x0 and out-of-range addresses decode to all zeros,
  // so the result doubles as a "trackable register" test.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    logic [NREGS-1:0] v;
    v = {NREGS{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      v[i] = (a == ADDR_W'(i));
    end
    return v;
  endfunction

  logic              r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [NREGS-1:0]  r_pending;
  logic              r_err;

  logic              w_alu_gnt;
  logic              w_lsu_gnt;
  logic              w_accept;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic [NREGS-1:0]  w_sel_oh;
  logic              w_sel_illegal;
  logic [NREGS-1:0]  w_hazard_oh;
  logic              w_stall;
  logic              w_issue;
  logic [NREGS-1:0]  w_clr_mask;
  logic [NREGS-1:0]  w_set_mask;
  logic [NREGS-1:0]  w_pending_nxt;

  // Round-robin grant: a tie goes to the source that did not win last time.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_lsu_gnt = 1'b0;
    if (!reset) begin
      w_alu_gnt = 1'b0;
      w_lsu_gnt = 1'b0;
    end else if (alu_valid_i && lsu_valid_i) begin
      w_alu_gnt = (r_last_grant == LG_LSU);
      w_lsu_gnt = (r_last_grant == LG_ALU);
    end else begin
      w_alu_gnt = alu_valid_i;
      w_lsu_gnt = lsu_valid_i;
    end
  end

  // Result mux, hazard detection and next scoreboard state.
  always_comb begin
    w_accept      = w_alu_gnt | w_lsu_gnt;
    w_sel_rd      = w_alu_gnt ? alu_rd_i : lsu_rd_i;
    w_sel_data    = w_alu_gnt ? alu_data_i : lsu_data_i;
    w_sel_oh      = reg_onehot(w_sel_rd);
    w_sel_illegal = (w_sel_rd >= ADDR_W'(NREGS));
    w_hazard_oh   = reg_onehot(iss_rs1_i) | reg_onehot(iss_rs2_i) | reg_onehot(iss_rd_i);
    w_stall       = (!reset) | (iss_valid_i & (|(w_hazard_oh & r_pending)));
    w_issue       = reset & iss_valid_i & ~w_stall;
    w_clr_mask    = r_we ? reg_onehot(r_waddr) : {NREGS{1'b0}};
    w_set_mask    = w_issue ? reg_onehot(iss_rd_i) : {NREGS{1'b0}};
    // Set applied after clear so a new producer wins over the committing one.
    w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
  end

  // Write-back stage, arbitration history and scoreboard state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_grant <= LG_LSU;
      r_we         <= 1'b0;
      r_waddr      <= {ADDR_W{1'b0}};
      r_wdata      <= {DATA_W{1'b0}};
      r_pending    <= {NREGS{1'b0}};
      r_err        <= 1'b0;
    end else begin
      r_we      <= w_accept & (|w_sel_oh);
      r_err     <= w_accept & w_sel_illegal;
      r_pending <= w_pending_nxt;
      if (w_accept) begin
        r_last_grant <= w_lsu_gnt ? LG_LSU : LG_ALU;
        r_waddr      <= w_sel_rd;
        r_wdata      <= w_sel_data;
      end else begin
        r_last_grant <= r_last_grant;
        r_waddr      <= r_waddr;
        r_wdata      <= r_wdata;
      end
    end
  end

  assign alu_ready_o = w_alu_gnt;
  assign lsu_ready_o = w_lsu_gnt;
  assign iss_stall_o = w_stall;
  assign rf_we_o     = r_we;
  assign rf_waddr_o  = r_waddr;
  assign rf_wdata_o  = r_wdata;
  assign pending_o   = r_pending;
  assign err_o       = r_err;

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench for rf_wb_scoreboard: arbitration order, write-back latency, scoreboard
// set/clear/stall behaviour, illegal-rd handling and reset.
module tb_rf_wb_scoreboard;

  logic        clk;
  logic        reset;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        iss_valid_i;
  logic [4:0]  iss_rd_i;
  logic [4:0]  iss_rs1_i;
  logic [4:0]  iss_rs2_i;
  logic        iss_stall_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [15:0] pending_o;
  logic        err_o;

  int n_total;
  int n_bad;

  rf_wb_scoreboard dut (
    .clk(clk), .reset(reset),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i), .iss_rs1_i(iss_rs1_i), .iss_rs2_i(iss_rs2_i),
    .iss_stall_o(iss_stall_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .pending_o(pending_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0; alu_rd_i = 5'd0; alu_data_i = 32'd0;
    lsu_valid_i = 1'b0; lsu_rd_i = 5'd0; lsu_data_i = 32'd0;
    iss_valid_i = 1'b0; iss_rd_i = 5'd0; iss_rs1_i = 5'd0; iss_rs2_i = 5'd0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    // Reset state, with requests present that must be refused
    alu_valid_i = 1'b1; iss_valid_i = 1'b1;
    #1;
    chk("rst_we",     32'(rf_we_o),     32'd0);
    chk("rst_waddr",  32'(rf_waddr_o),  32'd0);
    chk("rst_wdata",  rf_wdata_o,       32'd0);
    chk("rst_pend",   32'(pending_o),   32'd0);
    chk("rst_err",    32'(err_o),       32'd0);
    chk("rst_aready", 32'(alu_ready_o), 32'd0);
    chk("rst_stall",  32'(iss_stall_o), 32'd1);
    idle_inputs();
    reset = 1'b1;
    tick();

    // 1: single ALU result, latency 1
    alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'hDEADBEEF;
    #1;
    chk("t1_aready", 32'(alu_ready_o), 32'd1);
    tick();
    alu_valid_i = 1'b0;
    chk("t1_we",    32'(rf_we_o),    32'd1);
    chk("t1_waddr", 32'(rf_waddr_o), 32'd3);
    chk("t1_wdata", rf_wdata_o,      32'hDEADBEEF);
    tick();
    chk("t1_we_off",   32'(rf_we_o),    32'd0);
    chk("t1_waddr_hd", 32'(rf_waddr_o), 32'd3);

    // 2: both streams valid after reset -> ALU, LSU, ALU, LSU
    pulse_reset();
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'h1111_0005;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd6; lsu_data_i = 32'h2222_0006;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_aready", 32'(alu_ready_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_lready", 32'(lsu_ready_o), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("t2_we",    32'(rf_we_o),    32'd1);
      chk("t2_waddr", 32'(rf_waddr_o), (i % 2 == 0) ? 32'd5 : 32'd6);
      chk("t2_wdata", rf_wdata_o,      (i % 2 == 0) ? 32'h1111_0005 : 32'h2222_0006);
    end
    idle_inputs();
    tick();

    // 3: RAW stall on x7 until the cycle after its commit
    iss_valid_i = 1'b1; iss_rd_i = 5'd7;
    #1;
    chk("t3_iss_ok", 32'(iss_stall_o), 32'd0);
    tick();
    chk("t3_pend7", 32'(pending_o), 32'h0080);
    iss_rd_i = 5'd0; iss_rs1_i = 5'd7;
    alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h0000_0077;
    #1;
    chk("t3_stall_a", 32'(iss_stall_o), 32'd1);
    chk("t3_aready",  32'(alu_ready_o), 32'd1);
    tick();
    alu_valid_i = 1'b0;
    #1;
    chk("t3_we",      32'(rf_we_o),     32'd1);
    chk("t3_waddr",   32'(rf_waddr_o),  32'd7);
    chk("t3_stall_b", 32'(iss_stall_o), 32'd1);
    tick();
    chk("t3_pend_clr", 32'(pending_o),   32'h0000);
    chk("t3_stall_c",  32'(iss_stall_o), 32'd0);
    // RAW on rs2 and WAW on rd
    iss_rs1_i = 5'd0; iss_rd_i = 5'd2;
    tick();
    chk("t3_pend2", 32'(pending_o), 32'h0004);
    iss_rd_i = 5'd0; iss_rs2_i = 5'd2;
    #1;
    chk("t3_raw_rs2", 32'(iss_stall_o), 32'd1);
    iss_rs2_i = 5'd0; iss_rd_i = 5'd2;
    #1;
    chk("t3_waw_rd", 32'(iss_stall_o), 32'd1);
    // Illegal issue address is ignored by the hazard check and the scoreboard
    iss_rd_i = 5'd20;
    #1;
    chk("t3_ill_nostall", 32'(iss_stall_o), 32'd0);
    tick();
    chk("t3_ill_pend", 32'(pending_o), 32'h0004);
    idle_inputs();

    // 4: commit x9 and issue new x9 on the same edge -> pending[9] stays set
    alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_data_i = 32'h0000_0099;
    tick();
    alu_valid_i = 1'b0;
    iss_valid_i = 1'b1; iss_rd_i = 5'd9;
    #1;
    chk("t4_we",    32'(rf_we_o),     32'd1);
    chk("t4_stall", 32'(iss_stall_o), 32'd0);
    tick();
    chk("t4_pend9", 32'(pending_o), 32'h0204);
    iss_rd_i = 5'd0;
    #1;
    chk("t4_rd0_stall", 32'(iss_stall_o), 32'd0);
    tick();
    chk("t4_rd0_pend", 32'(pending_o), 32'h0204);
    idle_inputs();

    // 5: illegal and zero destinations from the LSU
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd20; lsu_data_i = 32'h0BAD_0BAD;
    #1;
    chk("t5_lready", 32'(lsu_ready_o), 32'd1);
    tick();
    lsu_valid_i = 1'b0;
    chk("t5_we",   32'(rf_we_o),   32'd0);
    chk("t5_err",  32'(err_o),     32'd1);
    chk("t5_pend", 32'(pending_o), 32'h0204);
    tick();
    chk("t5_err_off", 32'(err_o), 32'd0);
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd0; lsu_data_i = 32'h1234_5678;
    #1;
    chk("t5_lready0", 32'(lsu_ready_o), 32'd1);
    tick();
    lsu_valid_i = 1'b0;
    chk("t5_we0",  32'(rf_we_o), 32'd0);
    chk("t5_err0", 32'(err_o),   32'd0);

    // 6: reset mid-operation
    pulse_reset();
    iss_valid_i = 1'b1;
    for (int r = 4; r < 8; r++) begin
      iss_rd_i = 5'(r);
      tick();
    end
    iss_valid_i = 1'b0; iss_rd_i = 5'd0;
    chk("t6_pend", 32'(pending_o), 32'h00F0);
    alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_data_i = 32'h0000_0044;
    tick();
    chk("t6_inflight", 32'(rf_we_o), 32'd1);
    reset = 1'b0; iss_valid_i = 1'b1; iss_rd_i = 5'd8;
    #1;
    chk("t6_aready", 32'(alu_ready_o), 32'd0);
    chk("t6_stall",  32'(iss_stall_o), 32'd1);
    tick();
    chk("t6_pend_clr", 32'(pending_o),   32'h0000);
    chk("t6_we",       32'(rf_we_o),     32'd0);
    chk("t6_aready2",  32'(alu_ready_o), 32'd0);
    chk("t6_stall2",   32'(iss_stall_o), 32'd1);
    idle_inputs();
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
